alu_seq: RTL

- Parametrised, registered successor to the accumulator datapath ALU.
- Same 3-bit opcode space: add, shifts, xor, and, rotate, subtract, plus an iterative multi-cycle multiply in place of pass-A.
- Carry, overflow and zero are held in internal flag registers, so multi-word add, subtract and shift chains need no external carry plumbing.
- Sits between the register file / accumulator and the writeback mux, with a start/busy/done handshake to the controller.

---
 rtl/alu_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with carry/overflow/zero flag registers and a start/busy/done handshake.
// Build option ALU_SEQ_MUL_EN: opcode 111 becomes a W-cycle shift-add multiply (otherwise pass-A).
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         use_carry,
    input  logic [W-1:0] in_acc,
    input  logic [W-1:0] in_reg,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rslt,
    output logic [W-1:0] rslt_hi,
    output logic         carry,
    output logic         overflow,
    output logic         zero
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHL = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_ROL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    logic [W-1:0] rslt_q, rslt_d, rslt_hi_q, rslt_hi_d;
    logic         carry_q, carry_d, overflow_q, overflow_d, zero_q, zero_d, done_q, done_d;
    logic         accept, cin;
    logic [W-1:0] b_op;
    logic [W:0]   sum;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(W + 1);
    typedef enum logic {IDLE, MUL} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mca_q, mca_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [W:0]     psum;

    assign accept = start && (state_q == IDLE);
    assign busy   = (state_q == MUL);
`else
    assign accept = start;
    assign busy   = 1'b0;
`endif

    // next-state: single-cycle ops complete at acceptance; multiply steps once per cycle
    always_comb begin
        cin        = use_carry ? carry_q : (op == OP_SUB);
        b_op       = (op == OP_SUB) ? ~in_reg : in_reg;
        sum        = {1'b0, in_acc} + {1'b0, b_op} + {{W{1'b0}}, cin};
        rslt_d     = rslt_q;
        rslt_hi_d  = rslt_hi_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        state_d    = state_q;
        cnt_d      = cnt_q;
        mca_d      = mca_q;
        prod_d     = prod_q;
        psum       = {1'b0, prod_q[2*W-1:W]} + {1'b0, prod_q[0] ? mca_q : {W{1'b0}}};
        if (state_q == MUL) begin
            prod_d = {psum, prod_q[W-1:1]};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d    = IDLE;
                done_d     = 1'b1;
                rslt_d     = prod_d[W-1:0];
                rslt_hi_d  = prod_d[2*W-1:W];
                carry_d    = |prod_d[2*W-1:W];
                overflow_d = 1'b0;
            end
        end
`endif
        if (accept) begin
            done_d    = 1'b1;
            rslt_hi_d = '0;
            case (op)
                OP_ADD: begin
                    rslt_d     = sum[W-1:0];
                    carry_d    = sum[W];
                    overflow_d = (in_acc[W-1] == in_reg[W-1]) && (sum[W-1] != in_acc[W-1]);
                end
                OP_SHL: begin
                    rslt_d  = {in_acc[W-2:0], cin};
                    carry_d = in_acc[W-1];
                end
                OP_SHR: begin
                    rslt_d  = {cin, in_acc[W-1:1]};
                    carry_d = in_acc[0];
                end
                OP_XOR: begin
                    rslt_d     = in_acc ^ in_reg;
                    overflow_d = 1'b0;
                end
                OP_AND: begin
                    rslt_d     = in_acc & in_reg;
                    overflow_d = 1'b0;
                end
                OP_ROL: begin
                    rslt_d     = {in_acc[W-2:0], in_acc[W-1]};
                    overflow_d = 1'b0;
                end
                OP_SUB: begin
                    rslt_d     = sum[W-1:0];
                    carry_d    = sum[W];
                    overflow_d = (in_acc[W-1] != in_reg[W-1]) && (sum[W-1] != in_acc[W-1]);
                end
                default: begin
`ifdef ALU_SEQ_MUL_EN
                    done_d    = 1'b0;
                    rslt_hi_d = rslt_hi_q;
                    state_d   = MUL;
                    cnt_d     = CW'(W);
                    mca_d     = in_acc;
                    prod_d    = {{W{1'b0}}, in_reg};
`else
                    rslt_d     = in_acc;
                    overflow_d = 1'b0;
`endif
                end
            endcase
        end
        zero_d = (rslt_d == '0);
    end

    // state and result registers; reset clears everything immediately, zero flag reads 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rslt_q     <= '0;
            rslt_hi_q  <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q    <= IDLE;
            cnt_q      <= '0;
            mca_q      <= '0;
            prod_q     <= '0;
`endif
        end else begin
            rslt_q     <= rslt_d;
            rslt_hi_q  <= rslt_hi_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
`ifdef ALU_SEQ_MUL_EN
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mca_q      <= mca_d;
            prod_q     <= prod_d;
`endif
        end
    end

    assign rslt     = rslt_q;
    assign rslt_hi  = rslt_hi_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign done     = done_q;
endmodule
